// File: rtl/gcd_operand_bank.sv
// -----------------------------------------------------------------------------
// gcd_operand_bank
//
// SRAM-mapped operand/result bank for the GCD accelerator. N_ARGS writable
// operand slots and N_RES read-only result slots sit behind a 64-bit SRAM
// port. Slot 0xF is a control/status window with a GO/CLR handshake, a
// saturating busy-cycle counter, operand locking while the core runs and a
// level completion interrupt.
//
// Address map (byte address, only [11:3] decoded):
//   [11:8] slot, [7:3] 64-bit word within the 256 B slot
//   slot 0 .. N_ARGS-1             operands (R/W, locked while BUSY)
//   slot N_ARGS .. N_ARGS+N_RES-1  results (RO, zero-extended)
//   slot 0xF word 0  CTRL   bit0 GO (W1 action), bit1 CLR (W1 action),
//                           bit2 IRQ_EN (stored)
//   slot 0xF word 1  STATUS bit0 BUSY, bit1 DONE_FLAG, [15:8] N_ARGS,
//                           [23:16] N_RES
//   slot 0xF word 2  CYCLES busy cycles of the last/current run
//   everything else reads 0 and ignores writes
//
// Ports:
//   CLK         clock, rising edge
//   RESET       synchronous, active-high reset
//   SRAM_CEn    chip enable, active low
//   SRAM_ADDR   byte address
//   SRAM_WDATA  write data
//   SRAM_WEn    0 = write, 1 = read
//   SRAM_WBEn   byte write enables, active low
//   SRAM_RDATA  registered read data (1-cycle latency, held between reads)
//   ARG         operand k on [k*ARG_W +: ARG_W]
//   START       one-cycle start pulse to the GCD core
//   DONE        level from the core, results valid when high
//   RES         result r on [r*RES_W +: RES_W]
//   IRQ         DONE_FLAG & IRQ_EN
//
// Build option:
//   GCD_OPERAND_BANK_SNAPSHOT_EN  when defined, result slots read snapshot
//   registers captured on BUSY->CMPL; otherwise RES is read live.
// -----------------------------------------------------------------------------
module gcd_operand_bank #(
    parameter int ARG_W  = 1279,
    parameter int RES_W  = 1284,
    parameter int N_ARGS = 2,
    parameter int N_RES  = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      SRAM_CEn,
    input  logic [31:0]               SRAM_ADDR,
    input  logic [63:0]               SRAM_WDATA,
    input  logic                      SRAM_WEn,
    input  logic [7:0]                SRAM_WBEn,
    output logic [63:0]               SRAM_RDATA,
    output logic [N_ARGS*ARG_W-1:0]   ARG,
    output logic                      START,
    input  logic                      DONE,
    input  logic [N_RES*RES_W-1:0]    RES,
    output logic                      IRQ
);

    // Every slot spans 32 words of 64 bits.
    localparam int SLOT_BITS = 2048;
    // Storable operand bits; anything at or above ARG_W is forced to 0.
    localparam logic [SLOT_BITS-1:0] ARG_MASK = {SLOT_BITS{1'b1}} >> (SLOT_BITS - ARG_W);
    localparam logic [3:0] CTRL_SLOT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_CMPL
    } state_t;

    state_t               state_q;
    logic                 start_q;
    logic                 done_flag_q;
    logic                 irq_en_q;
    logic [31:0]          cycles_q;
    logic [63:0]          rdata_q;
    logic [SLOT_BITS-1:0] arg_q [N_ARGS];
    logic [SLOT_BITS-1:0] res_ext [N_RES];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0]  slot;
    logic [4:0]  word;
    logic [10:0] bit_base;
    logic        wr_en;
    logic        rd_en;
    logic        ctrl_wr;
    logic        go_wr;
    logic        clr_wr;
    logic        done_accept;
    logic [63:0] arg_wmask;
    logic        unused_addr;

    assign slot     = SRAM_ADDR[11:8];
    assign word     = SRAM_ADDR[7:3];
    assign bit_base = {word, 6'b0};
    assign wr_en    = !SRAM_CEn && !SRAM_WEn;
    assign rd_en    = !SRAM_CEn &&  SRAM_WEn;

    assign unused_addr = ^{SRAM_ADDR[31:12], SRAM_ADDR[2:0]};

    // CTRL actions only fire when byte lane 0 is enabled.
    assign ctrl_wr = wr_en && (slot == CTRL_SLOT) && (word == 5'd0) && !SRAM_WBEn[0];
    assign go_wr   = ctrl_wr && SRAM_WDATA[0];
    assign clr_wr  = ctrl_wr && SRAM_WDATA[1];

    // The core's DONE is only trusted once START has been seen by it, so the
    // level sampled in the START cycle (possibly stale from a previous run)
    // is ignored. CLR in the same cycle aborts instead of completing.
    assign done_accept = (state_q == ST_BUSY) && !start_q && !clr_wr && DONE;

    assign arg_wmask = ARG_MASK[bit_base +: 64];

    // ------------------------------------------------------------------
    // Operand storage
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: operand storage is reset because ARG must read 0 after
        // reset; it is small enough to live in flops rather than an SRAM.
        if (RESET) begin
            for (int k = 0; k < N_ARGS; k++) begin
                arg_q[k] <= '0;
            end
        end else if (wr_en && (state_q != ST_BUSY)) begin
            for (int k = 0; k < N_ARGS; k++) begin
                if (slot == 4'(k)) begin
                    for (int j = 0; j < 8; j++) begin
                        if (!SRAM_WBEn[j]) begin
                            arg_q[k][bit_base + 11'(8 * j) +: 8] <=
                                SRAM_WDATA[8 * j +: 8] & arg_wmask[8 * j +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < N_ARGS; k++) begin : g_arg
        assign ARG[k * ARG_W +: ARG_W] = arg_q[k][ARG_W-1:0];
    end

    // ------------------------------------------------------------------
    // Result source: snapshot registers or live RES, zero-extended to a
    // full slot so the read mux can slice any word uniformly.
    // ------------------------------------------------------------------
`ifdef GCD_OPERAND_BANK_SNAPSHOT_EN
    logic [RES_W-1:0] snap_q [N_RES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int r = 0; r < N_RES; r++) begin
                snap_q[r] <= '0;
            end
        end else if (done_accept) begin
            for (int r = 0; r < N_RES; r++) begin
                snap_q[r] <= RES[r * RES_W +: RES_W];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < N_RES; r++) begin
            res_ext[r] = SLOT_BITS'(snap_q[r]);
        end
    end
`else
    always_comb begin
        for (int r = 0; r < N_RES; r++) begin
            res_ext[r] = SLOT_BITS'(RES[r * RES_W +: RES_W]);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [63:0] rd_word;

    always_comb begin
        // NOTE: default first so every path assigns rd_word and no latch
        // is inferred; unmapped slots and words fall through to 0.
        rd_word = '0;
        for (int k = 0; k < N_ARGS; k++) begin
            if (slot == 4'(k)) begin
                rd_word = arg_q[k][bit_base +: 64];
            end
        end
        for (int r = 0; r < N_RES; r++) begin
            if (slot == 4'(N_ARGS + r)) begin
                rd_word = res_ext[r][bit_base +: 64];
            end
        end
        if (slot == CTRL_SLOT) begin
            case (word)
                5'd0:    rd_word = {61'b0, irq_en_q, 2'b00};
                5'd1:    rd_word = {40'b0, 8'(N_RES), 8'(N_ARGS), 6'b0,
                                    done_flag_q, state_q == ST_BUSY};
                5'd2:    rd_word = {32'b0, cycles_q};
                default: rd_word = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, cycle counter and read register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments throughout sequential logic so every
        // register samples the pre-edge values regardless of statement order.
        if (RESET) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            done_flag_q <= 1'b0;
            irq_en_q    <= 1'b0;
            cycles_q    <= '0;
            rdata_q     <= '0;
        end else begin
            start_q <= 1'b0;

            if (ctrl_wr) begin
                irq_en_q <= SRAM_WDATA[2];
            end

            if ((state_q == ST_BUSY) && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_q <= cycles_q + 32'd1;
            end

            case (state_q)
                ST_IDLE, ST_CMPL: begin
                    // GO wins over CLR and over any DONE level here.
                    if (go_wr) begin
                        state_q     <= ST_BUSY;
                        start_q     <= 1'b1;
                        cycles_q    <= '0;
                        done_flag_q <= 1'b0;
                    end else if (clr_wr) begin
                        state_q     <= ST_IDLE;
                        done_flag_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // GO is ignored while a run is in flight.
                    if (clr_wr) begin
                        state_q <= ST_IDLE;
                    end else if (done_accept) begin
                        state_q     <= ST_CMPL;
                        done_flag_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (rd_en) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign SRAM_RDATA = rdata_q;
    assign START      = start_q;
    assign IRQ        = done_flag_q & irq_en_q;

endmodule

// File: tb/tb_gcd_operand_bank.sv
module tb_gcd_operand_bank;

    localparam int ARG_W   = 1279;
    localparam int RES_W   = 1284;
    localparam int N_ARGS  = 2;
    localparam int N_RES   = 8;
    localparam int ARG_TOT = N_ARGS * ARG_W;
    localparam int RES_TOT = N_RES * RES_W;

    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_CMPL = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                cen;
    logic                wen;
    logic [31:0]         addr;
    logic [63:0]         wdata;
    logic [7:0]          wben;
    logic [63:0]         rdata;
    logic [ARG_TOT-1:0]  arg;
    logic                start;
    logic                done;
    logic [RES_TOT-1:0]  res;
    logic                irq;

    int checks      = 0;
    int failures    = 0;
    int start_count = 0;

    gcd_operand_bank #(
        .ARG_W (ARG_W),
        .RES_W (RES_W),
        .N_ARGS(N_ARGS),
        .N_RES (N_RES)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .SRAM_CEn  (cen),
        .SRAM_ADDR (addr),
        .SRAM_WDATA(wdata),
        .SRAM_WEn  (wen),
        .SRAM_WBEn (wben),
        .SRAM_RDATA(rdata),
        .ARG       (arg),
        .START     (start),
        .DONE      (done),
        .RES       (res),
        .IRQ       (irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: byte-addressed operand memory plus run bookkeeping.
    // ------------------------------------------------------------------
    logic [7:0]  m_arg [N_ARGS][256];
    int          m_phase;
    logic        m_start;
    logic        m_done_flag;
    logic        m_irq_en;
    logic [31:0] m_cycles;
    logic [63:0] m_rdata;
`ifdef GCD_OPERAND_BANK_SNAPSHOT_EN
    logic [RES_W-1:0] m_snap [N_RES];
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_ARGS; k++)
            for (int b = 0; b < 256; b++) m_arg[k][b] = 8'h00;
        m_phase     = PH_IDLE;
        m_start     = 1'b0;
        m_done_flag = 1'b0;
        m_irq_en    = 1'b0;
        m_cycles    = 32'd0;
        m_rdata     = 64'd0;
`ifdef GCD_OPERAND_BANK_SNAPSHOT_EN
        for (int r = 0; r < N_RES; r++) m_snap[r] = '0;
`endif
    endtask

    function automatic logic [63:0] model_read(input logic [31:0] a);
        int s;
        int w;
        int b;
        logic [63:0] v;
        s = int'(a[11:8]);
        w = int'(a[7:3]);
        v = 64'd0;
        if (s < N_ARGS) begin
            for (int j = 0; j < 8; j++) v[8 * j +: 8] = m_arg[s][w * 8 + j];
        end else if (s < N_ARGS + N_RES) begin
            for (int i = 0; i < 64; i++) begin
                b = w * 64 + i;
                if (b < RES_W) begin
`ifdef GCD_OPERAND_BANK_SNAPSHOT_EN
                    v[i] = m_snap[s - N_ARGS][b];
`else
                    v[i] = res[(s - N_ARGS) * RES_W + b];
`endif
                end
            end
        end else if (s == 15) begin
            if (w == 0) v[2] = m_irq_en;
            if (w == 1) begin
                v[0]     = (m_phase == PH_BUSY);
                v[1]     = m_done_flag;
                v[15:8]  = 8'(N_ARGS);
                v[23:16] = 8'(N_RES);
            end
            if (w == 2) v[31:0] = m_cycles;
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int s;
        int w;
        int byte_idx;
        logic ctrl;
        logic go;
        logic clr;
        logic was_start;
        s = int'(addr[11:8]);
        w = int'(addr[7:3]);
        ctrl = !cen && !wen && (s == 15) && (w == 0) && !wben[0];
        go   = ctrl && wdata[0];
        clr  = ctrl && wdata[1];
        was_start = m_start;

        if (!cen && wen) m_rdata = model_read(addr);

        if (!cen && !wen && (m_phase != PH_BUSY) && (s < N_ARGS)) begin
            for (int j = 0; j < 8; j++) begin
                byte_idx = w * 8 + j;
                if (!wben[j])
                    for (int i = 0; i < 8; i++)
                        if (byte_idx * 8 + i < ARG_W) m_arg[s][byte_idx][i] = wdata[8 * j + i];
            end
        end

        m_start = 1'b0;
        if (ctrl) m_irq_en = wdata[2];
        if (m_phase == PH_BUSY) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            if (clr) begin
                m_phase = PH_IDLE;
            end else if (done && !was_start) begin
                m_phase     = PH_CMPL;
                m_done_flag = 1'b1;
`ifdef GCD_OPERAND_BANK_SNAPSHOT_EN
                for (int r = 0; r < N_RES; r++) m_snap[r] = res[r * RES_W +: RES_W];
`endif
            end
        end else if (go) begin
            m_phase     = PH_BUSY;
            m_start     = 1'b1;
            m_cycles    = 32'd0;
            m_done_flag = 1'b0;
        end else if (clr) begin
            m_phase     = PH_IDLE;
            m_done_flag = 1'b0;
        end
    endtask

    // Compare ARG against the model; report the first differing 64-bit chunk.
    task automatic check_arg();
        logic [ARG_TOT+63:0] ep;
        logic [ARG_TOT+63:0] op;
        int first;
        ep = '0;
        op = '0;
        op[ARG_TOT-1:0] = arg;
        for (int k = 0; k < N_ARGS; k++)
            for (int b = 0; b < ARG_W; b++) ep[k * ARG_W + b] = m_arg[k][b / 8][b % 8];
        first = -1;
        for (int i = 0; i * 64 < ARG_TOT; i++)
            if (first < 0 && op[i * 64 +: 64] !== ep[i * 64 +: 64]) first = i;
        if (first < 0) first = 0;
        check($sformatf("arg_chunk%0d", first), op[first * 64 +: 64], ep[first * 64 +: 64]);
    endtask

    // One clock: let the DUT take the edge, step the model, compare outputs.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        if (start === 1'b1) start_count++;
        check("start", 64'(start), 64'(m_start));
        check("irq", 64'(irq), 64'(m_done_flag & m_irq_en));
        check("rdata", rdata, m_rdata);
        check_arg();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        cen = 1'b0; wen = 1'b0; addr = a; wdata = d; wben = be;
        cycle();
        cen = 1'b1; wen = 1'b1; wben = 8'hFF;
    endtask

    task automatic rd(input logic [31:0] a);
        cen = 1'b0; wen = 1'b1; addr = a;
        cycle();
        cen = 1'b1;
    endtask

    task automatic fill_res_slot(input int r, input logic [7:0] pat);
        for (int b = 0; b < RES_W; b++) res[r * RES_W + b] = pat[b % 8];
    endtask

    task automatic randomize_res();
        for (int b = 0; b < RES_TOT; b++) res[b] = 1'($urandom);
    endtask

    logic [63:0] exp_snap;
    logic [63:0] exp_top;

    initial begin
        reset = 1'b1; cen = 1'b1; wen = 1'b1; wben = 8'hFF;
        addr = '0; wdata = '0; done = 1'b0; res = '0;
        idle(2);
        reset = 1'b0;

        // Reset state
        rd(32'h000); check("rd_slot0_reset", rdata, 64'h0);
        rd(32'hF08); check("status_reset", rdata, 64'h0000_0000_0008_0200);
        rd(32'hF10); check("cycles_reset", rdata, 64'h0);
        check("arg_lo_reset", arg[63:0], 64'h0);
        check("irq_reset", 64'(irq), 64'h0);

        // Byte-enabled operand writes and top-word truncation
        wr(32'h008, 64'h0123_4567_89AB_CDEF, 8'hF0);
        rd(32'h008); check("partial_write", rdata, 64'h0000_0000_89AB_CDEF);
        wr(32'h108, 64'hDEAD_BEEF_CAFE_F00D, 8'h00);
        rd(32'h108); check("full_write", rdata, 64'hDEAD_BEEF_CAFE_F00D);
        check("arg0_word1", arg[64 +: 64], 64'h0000_0000_89AB_CDEF);
        check("arg1_word1", arg[ARG_W + 64 +: 64], 64'hDEAD_BEEF_CAFE_F00D);
        wr(32'h098, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd(32'h098); check("arg_top_word", rdata, 64'h7FFF_FFFF_FFFF_FFFF);

        // Full run with IRQ enabled
        start_count = 0;
        wr(32'hF00, 64'h5, 8'hFE);
        idle(10);
        done = 1'b1; cycle(); done = 1'b0;
        rd(32'hF10); check("cycles_run", rdata, 64'd11);
        check("start_once", 64'(start_count), 64'd1);
        rd(32'hF08); check("status_cmpl", rdata, 64'h0000_0000_0008_0202);
        check("irq_set", 64'(irq), 64'h1);
        wr(32'hF00, 64'h6, 8'hFE);
        check("irq_clr", 64'(irq), 64'h0);

        // Lock while BUSY, GO ignored, then snapshot vs live results
        start_count = 0;
        wr(32'hF00, 64'h1, 8'hFE);
        idle(2);
        wr(32'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        wr(32'hF00, 64'h1, 8'hFE);
        idle(2);
        rd(32'h000); check("operand_lock", rdata, 64'h0);
        check("no_restart", 64'(start_count), 64'd1);
        rd(32'hF10); check("cycles_busy", rdata, 64'd7);
        fill_res_slot(0, 8'hA5);
        done = 1'b1; cycle(); done = 1'b0;
        fill_res_slot(0, 8'h5A);
`ifdef GCD_OPERAND_BANK_SNAPSHOT_EN
        exp_snap = 64'hA5A5_A5A5_A5A5_A5A5;
        exp_top  = 64'h5;
`else
        exp_snap = 64'h5A5A_5A5A_5A5A_5A5A;
        exp_top  = 64'hA;
`endif
        rd(32'h200); check("result_word0", rdata, exp_snap);
        rd(32'h2A0); check("result_top_word", rdata, exp_top);
        rd(32'h2A8); check("result_beyond", rdata, 64'h0);
        rd(32'hE00); check("unmapped_slot", rdata, 64'h0);
        wr(32'hF00, 64'h2, 8'hFE);

        // CLR aborts a run; DONE in IDLE is ignored
        wr(32'hF00, 64'h1, 8'hFE);
        idle(3);
        wr(32'hF00, 64'h2, 8'hFE);
        rd(32'hF08); check("status_abort", rdata, 64'h0000_0000_0008_0200);
        done = 1'b1; cycle(); done = 1'b0;
        rd(32'hF08); check("done_idle_ignored", rdata, 64'h0000_0000_0008_0200);

        // Reset in the middle of a run
        start_count = 0;
        wr(32'hF00, 64'h1, 8'hFE);
        idle(3);
        reset = 1'b1; cycle(); reset = 1'b0;
        idle(2);
        rd(32'hF08); check("status_after_reset", rdata, 64'h0000_0000_0008_0200);
        rd(32'hF10); check("cycles_after_reset", rdata, 64'h0);
        check("single_start_reset", 64'(start_count), 64'd1);

        // Randomised traffic against the model
        randomize_res();
        for (int n = 0; n < 3000; n++) begin
            int op;
            int s;
            int w;
            logic [3:0] slot;
            if (n % 256 == 0) randomize_res();
            s = $urandom_range(0, 11);
            slot = (s < 10) ? 4'(s) : ((s == 10) ? 4'hE : 4'hF);
            w = (slot == 4'hF) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            addr = {20'($urandom), slot, 5'(w), 3'($urandom)};
            done = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 999) == 0);
            op = $urandom_range(0, 9);
            if (op < 4) begin
                cen = 1'b0; wen = 1'b1;
            end else if (op < 7) begin
                cen = 1'b0; wen = 1'b0;
                wben = 8'($urandom);
                wdata = {$urandom, $urandom};
                if (slot == 4'hF && w == 0) begin
                    wdata = 64'h0;
                    wdata[0] = ($urandom_range(0, 3) == 0);
                    wdata[1] = ($urandom_range(0, 15) == 0);
                    wdata[2] = 1'($urandom);
                end
            end else begin
                cen = 1'b1; wen = 1'b1;
            end
            cycle();
            cen = 1'b1; wen = 1'b1; wben = 8'hFF; reset = 1'b0; done = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_operand_bank.md
# gcd_operand_bank

Parametrised SRAM-mapped operand/result bank for the GCD accelerator, the successor to the fixed two-argument unpacker. It exposes N_ARGS writable operand slots and N_RES read-only result slots through the 64-bit SRAM port. It adds a control/status window with a start/done handshake, busy-time cycle counting, argument locking while the core runs, and optional coherent result snapshots.

## Interface
Parameters:
- ARG_W, 1279: operand width in bits; 1..2048.
- RES_W, 1284: result width in bits; 1..2048.
- N_ARGS, 2: number of operand slots; 1..14.
- N_RES, 8: number of result slots; N_ARGS+N_RES ≤ 15.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- SRAM_CEn  in  1  chip enable, active low.
- SRAM_ADDR  in  32  byte address; only [11:3] decoded.
- SRAM_WDATA  in  64  write data.
- SRAM_WEn  in  1  0 = write, 1 = read.
- SRAM_WBEn  in  8  byte write enables, active low.
- SRAM_RDATA  out  64  registered read data.
- ARG  out  N_ARGS*ARG_W  operand k is driven on [k*ARG_W +: ARG_W].
- START  out  1  one-cycle start pulse to the GCD core.
- DONE  in  1  level from the core; high means results are valid.
- RES  in  N_RES*RES_W  result r is on [r*RES_W +: RES_W].
- IRQ  out  1  completion interrupt, level.

## Operation
- Slot select is ADDR[11:8]; word select is ADDR[7:3]; each slot is 256 B (32 words).
  - Slots 0..N_ARGS-1 are operands (R/W).
  - Slots N_ARGS..N_ARGS+N_RES-1 are results (RO).
  - Slot 0xF is control.
  - All other slots read 0 and ignore writes.
- Operand write: each byte j with WBEn[j]=0 updates storage bits [64*word+8*j +: 8].
  - Bits at or above ARG_W are dropped on write and read back as 0.
  - Operand writes are ignored while state = BUSY (lock).
- Result read: returns the zero-extended result word; bits at or above RES_W read 0.
- Control window (slot 0xF):
  - 0xF00 CTRL (RW): bit0 GO (write-1 action, reads 0), bit1 CLR (write-1 action, reads 0), bit2 IRQ_EN (stored).
  - 0xF08 STATUS (RO): bit0 BUSY, bit1 DONE_FLAG, [15:8] N_ARGS, [23:16] N_RES.
  - 0xF10 CYCLES (RO): 32-bit count of BUSY cycles in the last or current run.
  - CTRL byte enables apply: GO, CLR and IRQ_EN take effect only if WBEn[0]=0.
- FSM has three states: IDLE, BUSY, CMPL.
  - IDLE/CMPL → BUSY on a GO write. This asserts START for exactly the next cycle, clears CYCLES and clears DONE_FLAG.
  - BUSY → CMPL on the first cycle with DONE=1 sampled at least one cycle after START. This sets DONE_FLAG and, with the snapshot build, captures RES.
  - CMPL → IDLE on a CLR write, which also clears DONE_FLAG.
  - GO while BUSY is ignored, with no START pulse.
  - CLR while BUSY aborts to IDLE without setting DONE_FLAG.
  - DONE in IDLE or CMPL is ignored.
- CYCLES increments every BUSY cycle and saturates at 0xFFFF_FFFF.
- IRQ = DONE_FLAG & IRQ_EN.

## Timing
- Reset values (RESET high at a clock edge):
  - SRAM_RDATA=0, START=0, IRQ=0.
  - All operand storage = 0, so ARG=0.
  - FSM=IDLE, CYCLES=0, IRQ_EN=0, DONE_FLAG=0, snapshot registers = 0.
- RESET takes priority over every access. Reset asserted during BUSY aborts the run with no START and no capture.
- Read latency is 1 cycle: address sampled with CEn=0, WEn=1 gives data on SRAM_RDATA the next cycle. SRAM_RDATA holds its value until the next read.
- A write is visible to a read issued in the following cycle.
- ARG updates 1 cycle after the write edge.
- GO write at edge t: START is high during cycle t+1 and BUSY reads 1 from t+1.
- DONE=1 sampled at edge t in BUSY: STATUS shows DONE_FLAG=1 and IRQ rises after edge t.
- Simultaneous GO write and DONE=1 in CMPL: GO wins and the FSM enters BUSY.

## Configuration
- GCD_OPERAND_BANK_SNAPSHOT_EN:
  - Defined: result slots read N_RES×RES_W snapshot registers loaded on the BUSY→CMPL transition. The registers are stable until the next capture.
  - Undefined: result slots read RES live (combinational into the read register), and there is no snapshot storage.
- All other behaviour is identical in both builds.

## Test plan
- Reset then read 0x000, 0xF08 and 0xF10: reads return 0, 0x0000_0000_0008_0200 and 0. ARG=0, START=0, IRQ=0.
- Write 0x0123456789ABCDEF to 0x008 with WBEn=0xF0, then read it: reads 0x0000_0000_89AB_CDEF. Write 0x108 with all bytes and read back: matches. ARG[64 +: 64] and ARG[ARG_W+64 +: 64] reflect the writes.
- Write CTRL=0x5, hold DONE=0 for 10 cycles, then pulse DONE:
  - START is high for exactly one cycle.
  - CYCLES reads 10 or 11 per the sampling rule.
  - STATUS bit1=1, IRQ=1; a CLR write drops IRQ next cycle.
- While BUSY, write 0xFF.. to operand slot 0 and write GO again: operand unchanged, no second START, CYCLES keeps counting.
- Snapshot build: drive RES slot 0 = 0xA5.., complete a run, change RES to 0x5A..; reading slot N_ARGS word 0 returns 0xA5... Non-snapshot build returns 0x5A...
- Read slot 0xE and a result word beyond RES_W (word 20 with RES_W=1284) → 0 and zero-extended upper bits respectively. Assert RESET mid-BUSY → IDLE, CYCLES=0, no START.
